// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MIPS multiply/divide unit that owns HI/LO.
// Define MDU_MADD_EN to compile in MADD/MADDU (ops 9/10); otherwise they decode as NONE.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] mdu_out
);
    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [63:0] res, res_next;
    logic        res_void, res_void_next;
    logic [31:0] hi_next, lo_next;

    logic [63:0] prod_s, prod_u;
    logic [31:0] dvd, dvs, q_mag, r_mag, q_div, r_div;
    logic        div_signed;
    logic        is_mul, is_div;

    // Signed divide works on magnitudes, so 0x80000000 / -1 naturally yields 0x80000000 rem 0.
    always_comb begin
        prod_s     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u     = {32'd0, A} * {32'd0, B};
        div_signed = (mdu_op == OP_DIV);
        dvd        = (div_signed && A[31]) ? -A : A;
        dvs        = (div_signed && B[31]) ? -B : B;
        q_mag      = dvd / dvs;
        r_mag      = dvd % dvs;
        q_div      = (div_signed && (A[31] ^ B[31])) ? -q_mag : q_mag;
        r_div      = (div_signed && A[31]) ? -r_mag : r_mag;
    end

    always_comb begin
        is_mul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (mdu_op == OP_MADD) || (mdu_op == OP_MADDU);
`endif
        is_div = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        res_next      = res;
        res_void_next = res_void;
        hi_next       = HI;
        lo_next       = LO;
        case (state)
            IDLE: begin
                if (start && (is_mul || is_div)) begin
                    state_next    = RUN;
                    cnt_next      = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    res_void_next = is_div && (B == 32'd0);
                    case (mdu_op)
                        OP_MULT:  res_next = prod_s;
                        OP_MULTU: res_next = prod_u;
                        OP_MADD:  res_next = {HI, LO} + prod_s;
                        OP_MADDU: res_next = {HI, LO} + prod_u;
                        default:  res_next = {r_div, q_div};
                    endcase
                end else if (mdu_op == OP_MTHI) begin
                    hi_next = A;
                end else if (mdu_op == OP_MTLO) begin
                    lo_next = A;
                end
            end
            RUN: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = IDLE;
                    if (!res_void) begin
                        {hi_next, lo_next} = res;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            HI    <= hi_next;
            LO    <= lo_next;
        end
    end

    // NOTE: res/res_void are always loaded on acceptance before being read, so they carry no reset.
    always_ff @(posedge clk) begin
        res      <= res_next;
        res_void <= res_void_next;
    end

    assign busy = (state == RUN);

    always_comb begin
        case (mdu_op)
            OP_MFHI: mdu_out = HI;
            OP_MFLO: mdu_out = LO;
            default: mdu_out = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed scoreboard bench for mult_div_unit (default and MDU_MADD_EN builds).
module tb_mult_div_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO, mdu_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t sb_q[$];

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .mdu_out(mdu_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = s;
        mdu_op = op;
        A      = a;
        B      = b;
    endtask

    // Called just after the accepting edge; counts busy cycles until busy falls, then pops the scoreboard.
    task automatic finish_op(input string tag, input int n, input logic [31:0] old_hi, input logic [31:0] old_lo);
        int   cycles;
        exp_t e;
        logic held;
        cycles = 0;
        held   = 1'b1;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            if (HI !== old_hi || LO !== old_lo) held = 1'b0;
            step();
        end
        check({tag, "_busy_cycles"}, 32'(cycles), 32'(n));
        check({tag, "_hilo_held"}, {31'd0, held}, 32'd1);
        check({tag, "_sb_nonempty"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_HI"}, HI, e.hi);
            check({tag, "_LO"}, LO, e.lo);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int n);
        logic [31:0] oh, ol;
        exp_t e;
        oh = HI;
        ol = LO;
        e.hi = eh;
        e.lo = el;
        sb_q.push_back(e);
        drive(1'b1, op, a, b);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        finish_op(tag, n, oh, ol);
    endtask

    initial begin
        exp_t e;
        reset = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        repeat (3) step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_HI", HI, 32'd0);
        check("rst_LO", LO, 32'd0);
        reset = 1'b1;
        step();

        run_op("mult_neg3x5", 4'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MC);
        run_op("divu_100_7", 4'd4, 32'd100, 32'd7, 32'd2, 32'd14, DC);
        run_op("div_neg7_2", 4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DC);
        run_op("mult_pos_neg", 4'd1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, MC);

        drive(1'b0, 4'd7, 32'h1234_5678, 32'd0);
        step();
        check("mthi", HI, 32'h1234_5678);
        drive(1'b0, 4'd8, 32'hCAFE_F00D, 32'd0);
        step();
        check("mtlo", LO, 32'hCAFE_F00D);
        check("mtlo_hi_kept", HI, 32'h1234_5678);
        run_op("div_by_zero", 4'd3, 32'd55, 32'd0, 32'h1234_5678, 32'hCAFE_F00D, DC);
        drive(1'b0, 4'd5, 32'd0, 32'd0);
        #1;
        check("mfhi", mdu_out, 32'h1234_5678);
        mdu_op = 4'd6;
        #1;
        check("mflo", mdu_out, 32'hCAFE_F00D);
        mdu_op = 4'd0;
        #1;
        check("mdu_out_none", mdu_out, 32'd0);

        // Reset during the third busy cycle discards the pending product.
        drive(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        step();
        step();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_HI", HI, 32'd0);
        check("midrst_LO", LO, 32'd0);
        repeat (MC + 2) step();
        check("midrst_HI_late", HI, 32'd0);
        check("midrst_LO_late", LO, 32'd0);
        check("midrst_busy_late", {31'd0, busy}, 32'd0);

        // Starts inside RUN and on the last busy cycle are ignored; the next one is accepted.
        e.hi = 32'd0;
        e.lo = 32'd12;
        sb_q.push_back(e);
        drive(1'b1, 4'd1, 32'd3, 32'd4);
        step();
        check("b2b_busy0", {31'd0, busy}, 32'd1);
        drive(1'b1, 4'd2, 32'd9, 32'd9);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        repeat (MC - 2) step();
        check("b2b_last_busy", {31'd0, busy}, 32'd1);
        drive(1'b1, 4'd4, 32'd50, 32'd5);
        step();
        check("b2b_fall_busy", {31'd0, busy}, 32'd0);
        check("b2b_sb_nonempty", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("b2b_first_HI", HI, e.hi);
            check("b2b_first_LO", LO, e.lo);
        end
        e.hi = 32'd0;
        e.lo = 32'd42;
        sb_q.push_back(e);
        drive(1'b1, 4'd2, 32'd6, 32'd7);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        check("b2b_accept_busy", {31'd0, busy}, 32'd1);
        finish_op("b2b_second", MC, 32'd0, 32'd12);

        drive(1'b0, 4'd7, 32'd0, 32'd0);
        step();
        drive(1'b0, 4'd8, 32'hFFFF_FFFF, 32'd0);
        step();
`ifdef MDU_MADD_EN
        run_op("maddu_1x1", 4'd10, 32'd1, 32'd1, 32'd1, 32'd0, MC);
        run_op("madd_neg", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, MC);
`else
        drive(1'b1, 4'd10, 32'd1, 32'd1);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        check("maddu_off_busy", {31'd0, busy}, 32'd0);
        repeat (MC + 1) step();
        check("maddu_off_busy_late", {31'd0, busy}, 32'd0);
        check("maddu_off_HI", HI, 32'd0);
        check("maddu_off_LO", LO, 32'hFFFF_FFFF);
`endif
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
